alarm_ctrl: RTL and testbench

Alarm and buzzer controller for the watch. It sits directly downstream of the hour/minute/second counters and the key detectors. The block holds a user-set alarm time, compares it against the running BCD time, and drives a gated buzzer tone. It also outputs the alarm time and setting status to the LED display stage, and sounds a short chime on the hour-carry pulse.

---
 rtl/watch_pkg.sv | 36 +++
 rtl/bcd_wrap_inc.sv | 23 ++
 rtl/alarm_ctrl.sv | 178 +++++++++++++++++
 tb/tb_alarm_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared types and constants for the watch alarm path: controller states,
// BCD field limits and the display blink-select codes.
package watch_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_SET_HOUR = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_ARMED    = 3'd3,
        ST_RINGING  = 3'd4,
        ST_SNOOZE   = 3'd5
    } state_t;

    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] MIN_MAX  = 8'h59;

    localparam logic [1:0] SETTING_NONE = 2'b00;
    localparam logic [1:0] SETTING_HOUR = 2'b01;
    localparam logic [1:0] SETTING_MIN  = 2'b10;

    function automatic logic [1:0] setting_code(input state_t st);
        case (st)
            ST_SET_HOUR: setting_code = SETTING_HOUR;
            ST_SET_MIN:  setting_code = SETTING_MIN;
            default:     setting_code = SETTING_NONE;
        endcase
    endfunction

    function automatic logic led_on(input state_t st);
        case (st)
            ST_ARMED, ST_RINGING, ST_SNOOZE: led_on = 1'b1;
            default:                         led_on = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/bcd_wrap_inc.sv
// Two-digit BCD increment that wraps to 0x00 once the value reaches MAX.
module bcd_wrap_inc
    import watch_pkg::*;
#(
    parameter logic [7:0] MAX = MIN_MAX
) (
    input  logic [7:0] value,
    output logic [7:0] next_value
);

    // Values at or past MAX wrap, so a corrupted register still recovers to 0x00.
    always_comb begin
        next_value = 8'h00;
        if (value >= MAX) begin
            next_value = 8'h00;
        end else if (value[3:0] >= 4'h9) begin
            next_value = {value[7:4] + 4'h1, 4'h0};
        end else begin
            next_value = {value[7:4], value[3:0] + 4'h1};
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm and buzzer controller: holds the user alarm time, matches it against
// the running BCD time, and drives the ring/snooze/chime tone.
module alarm_ctrl
    import watch_pkg::*;
#(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300,
    parameter int CHIME_MS       = 200
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       TICK_1HZ,
    input  logic       TICK_1KHZ,
    input  logic [7:0] HOUR,
    input  logic [7:0] MINUTE,
    input  logic [7:0] SECOND,
    input  logic       KEY_MODE,
    input  logic       KEY_UP,
    input  logic       KEY_OK,
    input  logic       CHIME,
    output logic       BUZZER,
    output logic [7:0] ALARM_HOUR,
    output logic [7:0] ALARM_MINUTE,
    output logic       ALARM_LED,
    output logic [1:0] SETTING
);

    localparam int RING_W  = $clog2(RING_SECONDS + 1);
    localparam int SNZ_W   = $clog2(SNOOZE_SECONDS + 1);
    localparam int CHIME_W = $clog2(CHIME_MS + 1);

    state_t             state_r, state_nxt_s;
    logic [7:0]         alarm_hour_r, alarm_min_r, hour_inc_s, min_inc_s;
    logic [RING_W-1:0]  ring_cnt_r;
    logic [SNZ_W-1:0]   snz_cnt_r;
    logic [CHIME_W-1:0] chime_cnt_r;
    logic               match_s, match_q_r, trig_s;
    logic               chime_meta_r, chime_sync_r, chime_prev_r, chime_rise_s;
    logic               tone_r, led_r;
    logic [1:0]         setting_r;
    logic               key_ok_s, key_mode_s, key_up_s;
    logic               ring_done_s, snz_done_s, ring_enter_s, ring_stay_s;

    bcd_wrap_inc #(.MAX(HOUR_MAX)) u_hour_inc (.value(alarm_hour_r), .next_value(hour_inc_s));
    bcd_wrap_inc #(.MAX(MIN_MAX))  u_min_inc  (.value(alarm_min_r),  .next_value(min_inc_s));

    // Only the highest-priority key of a coincident group acts.
    assign key_ok_s   = KEY_OK;
    assign key_mode_s = KEY_MODE & ~KEY_OK;
    assign key_up_s   = KEY_UP & ~KEY_MODE & ~KEY_OK;

    assign match_s      = (HOUR == alarm_hour_r) && (MINUTE == alarm_min_r) && (SECOND == 8'h00);
    assign trig_s       = match_s & ~match_q_r;
    assign chime_rise_s = chime_sync_r & ~chime_prev_r;
    assign ring_done_s  = (ring_cnt_r == RING_W'(RING_SECONDS - 1));
    assign snz_done_s   = (snz_cnt_r == SNZ_W'(SNOOZE_SECONDS - 1));
    assign ring_enter_s = (state_nxt_s == ST_RINGING) && (state_r != ST_RINGING);
    assign ring_stay_s  = (state_nxt_s == ST_RINGING) && (state_r == ST_RINGING);

    // Next-state decode; keys take precedence over time events.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_DISARMED: begin
                if (key_ok_s)        state_nxt_s = ST_ARMED;
                else if (key_mode_s) state_nxt_s = ST_SET_HOUR;
                else                 state_nxt_s = state_r;
            end
            ST_SET_HOUR: begin
                if (key_ok_s)        state_nxt_s = ST_ARMED;
                else if (key_mode_s) state_nxt_s = ST_SET_MIN;
                else                 state_nxt_s = state_r;
            end
            ST_SET_MIN: begin
                if (key_ok_s || key_mode_s) state_nxt_s = ST_ARMED;
                else                        state_nxt_s = state_r;
            end
            ST_ARMED: begin
                if (key_ok_s)        state_nxt_s = ST_DISARMED;
                else if (key_mode_s) state_nxt_s = ST_SET_HOUR;
                else if (trig_s)     state_nxt_s = ST_RINGING;
                else                 state_nxt_s = state_r;
            end
            ST_RINGING: begin
                if (key_ok_s)                      state_nxt_s = ST_ARMED;
                else if (key_up_s)                 state_nxt_s = ST_SNOOZE;
                else if (TICK_1HZ && ring_done_s)  state_nxt_s = ST_ARMED;
                else                               state_nxt_s = state_r;
            end
            ST_SNOOZE: begin
                if (key_ok_s)                     state_nxt_s = ST_ARMED;
                else if (TICK_1HZ && snz_done_s)  state_nxt_s = ST_RINGING;
                else                              state_nxt_s = state_r;
            end
            default: state_nxt_s = ST_DISARMED;
        endcase
    end

    // State, alarm time, ring/snooze counters and registered status outputs.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_r      <= ST_DISARMED;
            alarm_hour_r <= 8'h00;
            alarm_min_r  <= 8'h00;
            ring_cnt_r   <= {RING_W{1'b0}};
            snz_cnt_r    <= {SNZ_W{1'b0}};
            match_q_r    <= 1'b0;
            setting_r    <= SETTING_NONE;
            led_r        <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            match_q_r <= match_s;
            setting_r <= setting_code(state_nxt_s);
            led_r     <= led_on(state_nxt_s);

            if (state_r == ST_SET_HOUR && key_up_s) alarm_hour_r <= hour_inc_s;
            else                                    alarm_hour_r <= alarm_hour_r;

            if (state_r == ST_SET_MIN && key_up_s) alarm_min_r <= min_inc_s;
            else                                   alarm_min_r <= alarm_min_r;

            if (ring_enter_s)                 ring_cnt_r <= {RING_W{1'b0}};
            else if (ring_stay_s && TICK_1HZ) ring_cnt_r <= ring_cnt_r + RING_W'(1);
            else                              ring_cnt_r <= ring_cnt_r;

            if (state_nxt_s == ST_SNOOZE && state_r != ST_SNOOZE)
                snz_cnt_r <= {SNZ_W{1'b0}};
            else if (state_r == ST_SNOOZE && TICK_1HZ && !snz_done_s)
                snz_cnt_r <= snz_cnt_r + SNZ_W'(1);
            else
                snz_cnt_r <= snz_cnt_r;
        end
    end

    // CHIME synchroniser, chime length counter and the tone flop.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            chime_meta_r <= 1'b0;
            chime_sync_r <= 1'b0;
            chime_prev_r <= 1'b0;
            chime_cnt_r  <= {CHIME_W{1'b0}};
            tone_r       <= 1'b0;
        end else begin
            chime_meta_r <= CHIME;
            chime_sync_r <= chime_meta_r;
            chime_prev_r <= chime_sync_r;

            if (ring_enter_s)
                chime_cnt_r <= {CHIME_W{1'b0}};
            else if (chime_rise_s && state_r != ST_RINGING)
                chime_cnt_r <= CHIME_W'(CHIME_MS);
            else if (chime_cnt_r != {CHIME_W{1'b0}} && TICK_1KHZ)
                chime_cnt_r <= chime_cnt_r - CHIME_W'(1);
            else
                chime_cnt_r <= chime_cnt_r;

            // Beep only on even ring seconds; the entry cycle itself stays silent.
            if (ring_stay_s) begin
                if (ring_cnt_r[0])  tone_r <= 1'b0;
                else if (TICK_1KHZ) tone_r <= ~tone_r;
                else                tone_r <= tone_r;
            end else if (ring_enter_s || state_r == ST_RINGING || chime_cnt_r == {CHIME_W{1'b0}}) begin
                tone_r <= 1'b0;
            end else if (TICK_1KHZ) begin
                tone_r <= ~tone_r;
            end else begin
                tone_r <= tone_r;
            end
        end
    end

    assign BUZZER       = tone_r;
    assign ALARM_HOUR   = alarm_hour_r;
    assign ALARM_MINUTE = alarm_min_r;
    assign ALARM_LED    = led_r;
    assign SETTING      = setting_r;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed-vector bench for alarm_ctrl: key entry, BCD wrap, ring, snooze,
// key priority, chime length and asynchronous reset.
module tb_alarm_ctrl;
    import watch_pkg::*;

    logic       CLOCK, RESET, TICK_1HZ, TICK_1KHZ;
    logic [7:0] HOUR, MINUTE, SECOND;
    logic       KEY_MODE, KEY_UP, KEY_OK, CHIME;
    logic       BUZZER;
    logic [7:0] ALARM_HOUR, ALARM_MINUTE;
    logic       ALARM_LED;
    logic [1:0] SETTING;

    int   errors  = 0;
    int   checks  = 0;
    int   toggles = 0;
    logic buz_prev = 1'b0;

    alarm_ctrl #(.RING_SECONDS(60), .SNOOZE_SECONDS(300), .CHIME_MS(200)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .TICK_1HZ(TICK_1HZ), .TICK_1KHZ(TICK_1KHZ),
        .HOUR(HOUR), .MINUTE(MINUTE), .SECOND(SECOND),
        .KEY_MODE(KEY_MODE), .KEY_UP(KEY_UP), .KEY_OK(KEY_OK), .CHIME(CHIME),
        .BUZZER(BUZZER), .ALARM_HOUR(ALARM_HOUR), .ALARM_MINUTE(ALARM_MINUTE),
        .ALARM_LED(ALARM_LED), .SETTING(SETTING)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    task automatic step();
        @(posedge CLOCK);
        #1;
        if (BUZZER !== buz_prev) toggles++;
        buz_prev = BUZZER;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press(input logic ok, input logic mode, input logic up);
        KEY_OK = ok; KEY_MODE = mode; KEY_UP = up;
        step();
        KEY_OK = 1'b0; KEY_MODE = 1'b0; KEY_UP = 1'b0;
    endtask

    task automatic press_up(input int n);
        for (int i = 0; i < n; i++) press(1'b0, 1'b0, 1'b1);
    endtask

    task automatic khz();
        TICK_1KHZ = 1'b1; step(); TICK_1KHZ = 1'b0; step();
    endtask

    task automatic hz();
        TICK_1HZ = 1'b1; step(); TICK_1HZ = 1'b0; step();
    endtask

    task automatic retrigger();
        SECOND = 8'h01; step();
        SECOND = 8'h00; step();
    endtask

    task automatic do_reset();
        RESET = 1'b0; steps(2);
        RESET = 1'b1; step();
        buz_prev = BUZZER;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        steps(2);
        checks++; if (dut.state_r !== ST_DISARMED) begin errors++; $display("FAIL reset_state: got %0d want %0d", dut.state_r, ST_DISARMED); end
        checks++; if ({ALARM_HOUR, ALARM_MINUTE} !== 16'h0000) begin errors++; $display("FAIL reset_alarm: got %h:%h want 00:00", ALARM_HOUR, ALARM_MINUTE); end
        checks++; if ({BUZZER, ALARM_LED, SETTING} !== 4'b0000) begin errors++; $display("FAIL reset_outputs: got buz=%b led=%b set=%b want 0 0 00", BUZZER, ALARM_LED, SETTING); end
        RESET = 1'b1;
        step();
        buz_prev = BUZZER;
    endtask

    task automatic test_bcd_wrap();
        press(1'b0, 1'b1, 1'b0);
        checks++; if (SETTING !== 2'b01) begin errors++; $display("FAIL set_hour_blink: got %b want 01", SETTING); end
        press_up(9);
        checks++; if (ALARM_HOUR !== 8'h09) begin errors++; $display("FAIL hour_09: got %h want 09", ALARM_HOUR); end
        press_up(1);
        checks++; if (ALARM_HOUR !== 8'h10) begin errors++; $display("FAIL hour_09_to_10: got %h want 10", ALARM_HOUR); end
        press_up(13);
        checks++; if (ALARM_HOUR !== 8'h23) begin errors++; $display("FAIL hour_23: got %h want 23", ALARM_HOUR); end
        press_up(1);
        checks++; if (ALARM_HOUR !== 8'h00) begin errors++; $display("FAIL hour_wrap: got %h want 00", ALARM_HOUR); end
        press(1'b0, 1'b1, 1'b0);
        checks++; if (SETTING !== 2'b10) begin errors++; $display("FAIL set_min_blink: got %b want 10", SETTING); end
        press_up(59);
        checks++; if (ALARM_MINUTE !== 8'h59) begin errors++; $display("FAIL min_59: got %h want 59", ALARM_MINUTE); end
        press_up(1);
        checks++; if (ALARM_MINUTE !== 8'h00) begin errors++; $display("FAIL min_wrap: got %h want 00", ALARM_MINUTE); end
        do_reset();
    endtask

    task automatic test_set_alarm();
        press(1'b0, 1'b1, 1'b0);
        press_up(7);
        press(1'b0, 1'b1, 1'b0);
        press_up(3);
        press(1'b0, 1'b1, 1'b0);
        checks++; if ({ALARM_HOUR, ALARM_MINUTE} !== 16'h0703) begin errors++; $display("FAIL alarm_time: got %h:%h want 07:03", ALARM_HOUR, ALARM_MINUTE); end
        checks++; if (dut.state_r !== ST_ARMED) begin errors++; $display("FAIL armed_state: got %0d want %0d", dut.state_r, ST_ARMED); end
        checks++; if ({ALARM_LED, SETTING} !== 3'b100) begin errors++; $display("FAIL armed_outputs: got led=%b set=%b want 1 00", ALARM_LED, SETTING); end
    endtask

    task automatic test_ring();
        state_t prev_st;
        int entries, even_tg, odd_tg, t0;
        HOUR = 8'h07; MINUTE = 8'h03; SECOND = 8'h59;
        step();
        entries = 0; prev_st = dut.state_r;
        SECOND = 8'h00;
        for (int i = 0; i < 1000; i++) begin
            KEY_OK = (i == 10);
            step();
            if (dut.state_r == ST_RINGING && prev_st != ST_RINGING) entries++;
            prev_st = dut.state_r;
        end
        KEY_OK = 1'b0;
        checks++; if (entries !== 1) begin errors++; $display("FAIL ring_entries: got %0d want 1", entries); end
        checks++; if (dut.state_r !== ST_ARMED) begin errors++; $display("FAIL held_match_armed: got %0d want %0d", dut.state_r, ST_ARMED); end

        retrigger();
        checks++; if ({dut.state_r, BUZZER} !== {ST_RINGING, 1'b0}) begin errors++; $display("FAIL ring_entry: got st=%0d buz=%b want %0d 0", dut.state_r, BUZZER, ST_RINGING); end
        toggles = 0;
        TICK_1KHZ = 1'b1; step(); TICK_1KHZ = 1'b0;
        checks++; if (BUZZER !== 1'b1) begin errors++; $display("FAIL first_buzzer_edge: got %b want 1", BUZZER); end
        step();
        even_tg = 0; odd_tg = 0;
        for (int s = 0; s < 60; s++) begin
            t0 = (s == 0) ? 0 : toggles;
            for (int k = (s == 0) ? 1 : 0; k < 4; k++) khz();
            if (s == 59) begin
                checks++; if (dut.state_r !== ST_RINGING) begin errors++; $display("FAIL ring_59s: got %0d want %0d", dut.state_r, ST_RINGING); end
            end
            hz();
            if (s % 2 == 0) even_tg += toggles - t0;
            else            odd_tg  += toggles - t0;
        end
        checks++; if (even_tg !== 120) begin errors++; $display("FAIL even_toggles: got %0d want 120", even_tg); end
        checks++; if (odd_tg !== 0) begin errors++; $display("FAIL odd_toggles: got %0d want 0", odd_tg); end
        checks++; if ({dut.state_r, BUZZER} !== {ST_ARMED, 1'b0}) begin errors++; $display("FAIL ring_timeout: got st=%0d buz=%b want %0d 0", dut.state_r, BUZZER, ST_ARMED); end
    endtask

    task automatic test_snooze();
        retrigger();
        press(1'b0, 1'b1, 1'b0);
        checks++; if (dut.state_r !== ST_RINGING) begin errors++; $display("FAIL mode_ignored_ring: got %0d want %0d", dut.state_r, ST_RINGING); end
        khz();
        checks++; if (BUZZER !== 1'b1) begin errors++; $display("FAIL ring_beep: got %b want 1", BUZZER); end
        press(1'b0, 1'b0, 1'b1);
        checks++; if ({dut.state_r, BUZZER} !== {ST_SNOOZE, 1'b0}) begin errors++; $display("FAIL snooze_entry: got st=%0d buz=%b want %0d 0", dut.state_r, BUZZER, ST_SNOOZE); end
        khz();
        retrigger();
        checks++; if ({dut.state_r, BUZZER} !== {ST_SNOOZE, 1'b0}) begin errors++; $display("FAIL snooze_quiet: got st=%0d buz=%b want %0d 0", dut.state_r, BUZZER, ST_SNOOZE); end
        for (int s = 0; s < 299; s++) hz();
        checks++; if (dut.state_r !== ST_SNOOZE) begin errors++; $display("FAIL snooze_299: got %0d want %0d", dut.state_r, ST_SNOOZE); end
        hz();
        checks++; if (dut.state_r !== ST_RINGING) begin errors++; $display("FAIL snooze_rering: got %0d want %0d", dut.state_r, ST_RINGING); end
        press(1'b1, 1'b0, 1'b0);
        checks++; if (dut.state_r !== ST_ARMED) begin errors++; $display("FAIL snooze_ok: got %0d want %0d", dut.state_r, ST_ARMED); end
    endtask

    task automatic test_back_to_back();
        retrigger();
        press(1'b1, 1'b0, 1'b1);
        checks++; if (dut.state_r !== ST_ARMED) begin errors++; $display("FAIL ok_over_up: got %0d want %0d", dut.state_r, ST_ARMED); end
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b1);
        checks++; if ({dut.state_r, ALARM_HOUR} !== {ST_SET_MIN, 8'h07}) begin errors++; $display("FAIL mode_over_up: got st=%0d hour=%h want %0d 07", dut.state_r, ALARM_HOUR, ST_SET_MIN); end
        press(1'b1, 1'b0, 1'b1);
        checks++; if ({dut.state_r, ALARM_MINUTE} !== {ST_ARMED, 8'h03}) begin errors++; $display("FAIL ok_in_set_min: got st=%0d min=%h want %0d 03", dut.state_r, ALARM_MINUTE, ST_ARMED); end
        press(1'b1, 1'b0, 1'b0);
        checks++; if ({dut.state_r, ALARM_LED} !== {ST_DISARMED, 1'b0}) begin errors++; $display("FAIL disarm: got st=%0d led=%b want %0d 0", dut.state_r, ALARM_LED, ST_DISARMED); end
    endtask

    task automatic test_chime();
        CHIME = 1'b1;
        steps(2);
        TICK_1KHZ = 1'b1; step(); TICK_1KHZ = 1'b0;
        checks++; if (BUZZER !== 1'b0) begin errors++; $display("FAIL chime_early: got %b want 0", BUZZER); end
        toggles = 0;
        for (int i = 0; i < 200; i++) khz();
        checks++; if (toggles !== 200) begin errors++; $display("FAIL chime_toggles: got %0d want 200", toggles); end
        for (int i = 0; i < 4; i++) khz();
        checks++; if ({toggles, BUZZER} !== {32'sd200, 1'b0}) begin errors++; $display("FAIL chime_end: got tg=%0d buz=%b want 200 0", toggles, BUZZER); end

        CHIME = 1'b0; steps(3);
        CHIME = 1'b1; steps(3);
        khz();
        checks++; if (BUZZER !== 1'b1) begin errors++; $display("FAIL chime_restart: got %b want 1", BUZZER); end
        #2; RESET = 1'b0; #1;
        checks++; if ({BUZZER, ALARM_LED, ALARM_HOUR, ALARM_MINUTE} !== 18'h0) begin errors++; $display("FAIL async_reset: got buz=%b led=%b alarm=%h:%h want 0 0 00:00", BUZZER, ALARM_LED, ALARM_HOUR, ALARM_MINUTE); end
        checks++; if (dut.state_r !== ST_DISARMED) begin errors++; $display("FAIL async_reset_state: got %0d want %0d", dut.state_r, ST_DISARMED); end
        #2; RESET = 1'b1; CHIME = 1'b0;
        step();
        buz_prev = BUZZER;
    endtask

    initial begin
        RESET = 1'b0; TICK_1HZ = 1'b0; TICK_1KHZ = 1'b0;
        HOUR = 8'h00; MINUTE = 8'h00; SECOND = 8'h30;
        KEY_MODE = 1'b0; KEY_UP = 1'b0; KEY_OK = 1'b0; CHIME = 1'b0;
        test_reset();
        test_bcd_wrap();
        test_set_alarm();
        test_ring();
        test_snooze();
        test_back_to_back();
        test_chime();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
